stopwatch_controller: RTL and testbench

//   Sequencer for a multi-digit BCD stopwatch: edge-detects the start_resume/stop/clear/lap buttons,

---
 rtl/stopwatch_controller_pkg.sv | 17 +
 rtl/stopwatch_controller_bcd_digit_counter.sv | 25 ++
 rtl/stopwatch_controller.sv | 123 ++++++++++++
 tb/tb_stopwatch_controller.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_controller_pkg.sv
// Shared definitions for the stopwatch controller: FSM state encoding and BCD digit helpers.
package stopwatch_controller_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_t;

    localparam logic [3:0] BCD_MAX = 4'd9;

    // Next BCD value; anything at or above 9 folds back to 0 so no non-BCD code can persist.
    function automatic logic [3:0] bcd_inc(input logic [3:0] d);
        return (d >= BCD_MAX) ? 4'd0 : d + 4'd1;
    endfunction

endpackage

// File: rtl/stopwatch_controller_bcd_digit_counter.sv
// One BCD digit of the stopwatch count chain; carry is combinational so a whole chain rolls over in one cycle.
module bcd_digit_counter
    import stopwatch_controller_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       clr,
    input  logic       en,
    output logic [3:0] q,
    output logic       carry
);

    assign carry = en && (q == BCD_MAX);

    always_ff @(posedge clk) begin
        if (!reset) begin
            q <= 4'd0;
        end else if (clr) begin
            q <= 4'd0;
        end else if (en) begin
            q <= bcd_inc(q);
        end
    end

endmodule

// File: rtl/stopwatch_controller.sv
// Stopwatch sequencer: button edge detection, IDLE/RUN/PAUSE FSM, tick prescaler, BCD digit chain,
// lap capture and sticky overflow.
module stopwatch_controller
    import stopwatch_controller_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int TICK_DIV   = 10
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start_resume,
    input  logic                    stop,
    input  logic                    clear,
    input  logic                    lap,
    output logic [4*NUM_DIGITS-1:0] digits,
    output logic [4*NUM_DIGITS-1:0] lap_digits,
    output logic                    lap_valid,
    output logic                    running,
    output logic                    overflow
);

    localparam int            PW         = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

    logic [3:0]            btn;
    logic [3:0]            btn_q;
    logic [3:0]            evt;
    logic                  evt_start;
    logic                  evt_stop;
    logic                  evt_clear;
    logic                  evt_lap;
    state_t                state;
    logic [PW-1:0]         presc;
    logic                  tick;
    logic                  clr_cnt;
    logic [NUM_DIGITS-1:0] en;
    logic [NUM_DIGITS-1:0] carry;

    assign btn       = {lap, clear, stop, start_resume};
    assign evt       = btn & ~btn_q;
    assign evt_start = evt[0];
    assign evt_stop  = evt[1];
    assign evt_clear = evt[2];
    assign evt_lap   = evt[3];

    assign tick    = (state == ST_RUN) && (presc == PRESC_LAST);
    // Clear is honoured only outside RUN, and it wins over a simultaneous start.
    assign clr_cnt = evt_clear && (state != ST_RUN);

    assign en[0] = tick;
    for (genvar i = 1; i < NUM_DIGITS; i++) begin : g_chain
        assign en[i] = carry[i-1];
    end

    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
        bcd_digit_counter u_digit (
            .clk   (clk),
            .reset (reset),
            .clr   (clr_cnt),
            .en    (en[i]),
            .q     (digits[4*i +: 4]),
            .carry (carry[i])
        );
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= ST_IDLE;
            running    <= 1'b0;
            presc      <= '0;
            btn_q      <= '1;
            lap_digits <= '0;
            lap_valid  <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            btn_q     <= btn;
            lap_valid <= 1'b0;
            if (tick && carry[NUM_DIGITS-1]) begin
                overflow <= 1'b1;
            end
            case (state)
                ST_IDLE: begin
                    presc <= '0;
                    if (evt_clear) begin
                        overflow <= 1'b0;
                    end else if (evt_start) begin
                        state   <= ST_RUN;
                        running <= 1'b1;
                    end
                end
                ST_RUN: begin
                    presc <= tick ? '0 : presc + 1'b1;
                    // Captured value is the count before this cycle's tick lands.
                    if (evt_lap) begin
                        lap_digits <= digits;
                        lap_valid  <= 1'b1;
                    end
                    if (evt_stop) begin
                        state   <= ST_PAUSE;
                        running <= 1'b0;
                    end
                end
                ST_PAUSE: begin
                    if (evt_clear) begin
                        state    <= ST_IDLE;
                        running  <= 1'b0;
                        presc    <= '0;
                        overflow <= 1'b0;
                    end else if (evt_start) begin
                        state   <= ST_RUN;
                        running <= 1'b1;
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    running <= 1'b0;
                    presc   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stopwatch_controller.sv
// Bench for stopwatch_controller: directed scenarios plus random button traffic against an integer-count model.
module tb_stopwatch_controller;

    localparam int ND  = 2;
    localparam int TD  = 4;
    localparam int MOD = 100;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start_resume = 1'b1;
    logic          stop = 1'b0;
    logic          clear = 1'b0;
    logic          lap = 1'b0;
    logic [4*ND-1:0] digits;
    logic [4*ND-1:0] lap_digits;
    logic          lap_valid;
    logic          running;
    logic          overflow;

    int vectors = 0;
    int miscompares = 0;

    // Model: 0 = stopped at zero, 1 = counting, 2 = paused
    int         m_state = 0;
    int         m_cnt = 0;
    int         m_phase = 0;
    int         m_lap = 0;
    int         m_lapv = 0;
    int         m_ovf = 0;
    logic [3:0] m_prev = 4'hF;
    logic       found;

    stopwatch_controller #(.NUM_DIGITS(ND), .TICK_DIV(TD)) dut (
        .clk          (clk),
        .reset        (reset),
        .start_resume (start_resume),
        .stop         (stop),
        .clear        (clear),
        .lap          (lap),
        .digits       (digits),
        .lap_digits   (lap_digits),
        .lap_valid    (lap_valid),
        .running      (running),
        .overflow     (overflow)
    );

    always #5 clk = ~clk;

    function automatic logic [4*ND-1:0] to_bcd(input int v);
        logic [4*ND-1:0] r;
        for (int i = 0; i < ND; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_step();
        logic [3:0] b;
        logic [3:0] e;
        logic       tck;
        b = {lap, clear, stop, start_resume};
        if (!reset) begin
            m_state = 0; m_cnt = 0; m_phase = 0; m_lap = 0; m_lapv = 0; m_ovf = 0;
            m_prev = 4'hF;
        end else begin
            e = b & ~m_prev;
            m_prev = b;
            m_lapv = 0;
            case (m_state)
                0: begin
                    m_phase = 0;
                    if (!e[2] && e[0]) m_state = 1;
                end
                1: begin
                    tck = (m_phase == TD - 1);
                    m_phase = (m_phase + 1) % TD;
                    if (e[3]) begin
                        m_lap = m_cnt;
                        m_lapv = 1;
                    end
                    if (tck) begin
                        m_cnt++;
                        if (m_cnt == MOD) begin
                            m_cnt = 0;
                            m_ovf = 1;
                        end
                    end
                    if (e[1]) m_state = 2;
                end
                default: begin
                    if (e[2]) begin
                        m_state = 0; m_cnt = 0; m_phase = 0; m_ovf = 0;
                    end else if (e[0]) begin
                        m_state = 1;
                    end
                end
            endcase
        end
    endtask

    task automatic compare_all();
        check_eq("digits", 32'(digits), 32'(to_bcd(m_cnt)));
        check_eq("lap_digits", 32'(lap_digits), 32'(to_bcd(m_lap)));
        check_eq("lap_valid", 32'(lap_valid), 32'(m_lapv));
        check_eq("running", 32'(running), 32'(m_state == 1));
        check_eq("overflow", 32'(overflow), 32'(m_ovf));
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    initial begin
        // Reset with start held: must not fire on release
        repeat (3) cycle();
        check_eq("reset_running", 32'(running), 32'd0);
        check_eq("reset_digits", 32'(digits), 32'd0);
        reset = 1'b1;
        repeat (3) cycle();
        check_eq("held_start_no_fire", 32'(running), 32'd0);

        // Start and count 10 ticks
        start_resume = 1'b0; cycle();
        start_resume = 1'b1; cycle();
        check_eq("start_running", 32'(running), 32'd1);
        repeat (40) cycle();
        check_eq("run40_digits", 32'(digits), 32'h10);
        start_resume = 1'b0;

        // Pause mid-period at 23 and resume
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            cycle();
            if (m_cnt == 23 && m_phase == 1) found = 1'b1;
        end
        check_eq("reach_23", 32'(found), 32'd1);
        stop = 1'b1; cycle(); stop = 1'b0;
        repeat (20) cycle();
        check_eq("pause_hold", 32'(digits), 32'h23);
        check_eq("pause_running", 32'(running), 32'd0);
        start_resume = 1'b1; cycle();
        check_eq("resume_0", 32'(digits), 32'h23);
        cycle();
        check_eq("resume_1", 32'(digits), 32'h23);
        cycle();
        check_eq("resume_2", 32'(digits), 32'h24);
        start_resume = 1'b0;

        // Overflow wrap, clear ignored in RUN, then stop and clear
        found = 1'b0;
        for (int i = 0; i < 600 && !found; i++) begin
            cycle();
            if (m_ovf != 0) found = 1'b1;
        end
        check_eq("reach_wrap", 32'(found), 32'd1);
        check_eq("wrap_digits", 32'(digits), 32'h00);
        check_eq("wrap_overflow", 32'(overflow), 32'd1);
        clear = 1'b1; cycle(); clear = 1'b0; cycle();
        check_eq("clear_in_run_ovf", 32'(overflow), 32'd1);
        check_eq("clear_in_run_running", 32'(running), 32'd1);
        stop = 1'b1; cycle(); stop = 1'b0;
        clear = 1'b1; cycle(); clear = 1'b0;
        check_eq("clear_digits", 32'(digits), 32'h00);
        check_eq("clear_overflow", 32'(overflow), 32'd0);
        cycle();
        check_eq("clear_running", 32'(running), 32'd0);

        // Lap on the tick cycle at 15
        start_resume = 1'b1; cycle(); start_resume = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            cycle();
            if (m_cnt == 15 && m_phase == 3) found = 1'b1;
        end
        check_eq("reach_15", 32'(found), 32'd1);
        lap = 1'b1; cycle(); lap = 1'b0;
        check_eq("lap_value", 32'(lap_digits), 32'h15);
        check_eq("lap_pulse", 32'(lap_valid), 32'd1);
        check_eq("lap_tick_digits", 32'(digits), 32'h16);
        cycle();
        check_eq("lap_pulse_end", 32'(lap_valid), 32'd0);

        // Stop+start together: stop wins; resume, then reset mid-run
        stop = 1'b1; start_resume = 1'b1; cycle();
        check_eq("stop_wins", 32'(running), 32'd0);
        stop = 1'b0; start_resume = 1'b0; cycle();
        start_resume = 1'b1; cycle();
        check_eq("resume_run", 32'(running), 32'd1);
        start_resume = 1'b0;
        repeat (5) cycle();
        reset = 1'b0; cycle();
        check_eq("midrun_reset_digits", 32'(digits), 32'd0);
        check_eq("midrun_reset_lap", 32'(lap_digits), 32'd0);
        check_eq("midrun_reset_running", 32'(running), 32'd0);
        reset = 1'b1;

        // Random button traffic
        for (int i = 0; i < 3000; i++) begin
            reset        = ($urandom_range(0, 399) != 0);
            start_resume = ($urandom_range(0, 3) == 0);
            stop         = ($urandom_range(0, 11) == 0);
            clear        = ($urandom_range(0, 13) == 0);
            lap          = ($urandom_range(0, 3) == 0);
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
